// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// Each queue entry is one 32-bit instruction tagged with its pc.
package fetch_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage : fetch_pkg

// File: rtl/fetch_buffer_ram.sv
// Entry storage for the fetch buffer: two write ports at consecutive
// indices (idx, idx+1 with wrap) and one asynchronous read port.
module fetch_buffer_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       we0_i,
  input  logic                       we1_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  fetch_entry_t               wdata0_i,
  input  fetch_entry_t               wdata1_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output fetch_entry_t               rdata_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  waddr1;

  // The second slot wraps to index 0 when the first lands on DEPTH-1.
  assign waddr1 = waddr_i + AW'(1);

  // NOTE: storage carries no reset; validity is tracked entirely by the
  // pointers and count, so clearing the array would only cost area.
  always_ff @(posedge clock) begin
    if (we0_i) mem_q[waddr_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1]  <= wdata1_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fetch_buffer_ram

// File: rtl/fetch_buffer.sv
// Decoupling queue between fetch and decode: splits 64-bit fetch packets into
// 32-bit instructions and hands them to decode one per valid/ready handshake.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [63:0]               in_pc,
  input  logic [63:0]               in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [63:0]               out_pc,
  output logic [31:0]               out_inst,
  output logic [$clog2(DEPTH):0]    out_count,
  input  logic                      flush
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          enq, deq, two_slot;
  logic [1:0]    enq_n;
  fetch_entry_t  wr0, wr1, rd;

  // Space check uses only the registered count, so a same-cycle dequeue
  // never opens room and there is no path from in_valid to in_ready.
  assign in_ready  = reset && !flush && (count_q <= CW'(DEPTH - 2));
  assign out_valid = (count_q != '0) && !flush;

  assign enq      = in_valid && in_ready;
  assign deq      = out_valid && out_ready;
  assign two_slot = !in_pc[2];

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    enq_n = 2'd0;
    if (enq) enq_n = two_slot ? 2'd2 : 2'd1;

    wr0.pc   = in_pc;
    wr0.inst = two_slot ? in_data[31:0] : in_data[63:32];
    wr1.pc   = in_pc + 64'd4;
    wr1.inst = in_data[63:32];

    wptr_d  = wptr_q + AW'(enq_n);
    rptr_d  = rptr_q + AW'(deq);
    count_d = count_q + CW'(enq_n) - CW'(deq);
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before this edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  fetch_buffer_ram #(.DEPTH(DEPTH)) u_ram (
    .clock    (clock),
    .we0_i    (enq),
    .we1_i    (enq && two_slot),
    .waddr_i  (wptr_q),
    .wdata0_i (wr0),
    .wdata1_i (wr1),
    .raddr_i  (rptr_q),
    .rdata_o  (rd)
  );

  assign out_pc    = out_valid ? rd.pc   : 64'd0;
  assign out_inst  = out_valid ? rd.inst : 32'd0;
  assign out_count = count_q;

endmodule : fetch_buffer

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a queue model of the expected entries;
// every cycle the outputs are compared to the model, plus directed checks.
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] in_pc, in_data;
  logic        out_valid, out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  out_count;
  logic        flush;

  int tests = 0;
  int fails = 0;
  fetch_entry_t sb[$];

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_count (out_count),
    .flush     (flush)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare outputs with the model, then advance the model and the clock.
  task automatic tick();
    logic exp_rdy, exp_vld;
    fetch_entry_t e;
    #1;
    exp_rdy = reset && !flush && ((DEPTH - sb.size()) >= 2);
    exp_vld = (sb.size() != 0) && !flush;
    check("model_count",     64'(out_count), 64'(sb.size()));
    check("model_in_ready",  64'(in_ready),  64'(exp_rdy));
    check("model_out_valid", 64'(out_valid), 64'(exp_vld));
    if (exp_vld) begin
      check("model_out_pc",   out_pc,          sb[0].pc);
      check("model_out_inst", 64'(out_inst),   64'(sb[0].inst));
    end else begin
      check("idle_out_pc",   out_pc,        64'd0);
      check("idle_out_inst", 64'(out_inst), 64'd0);
    end
    if (flush) begin
      sb.delete();
    end else begin
      if (exp_vld && out_ready) void'(sb.pop_front());
      if (in_valid && exp_rdy) begin
        e.pc = in_pc;
        e.inst = in_pc[2] ? in_data[63:32] : in_data[31:0];
        sb.push_back(e);
        if (!in_pc[2]) begin
          e.pc = in_pc + 64'd4;
          e.inst = in_data[63:32];
          sb.push_back(e);
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_data = '0;
    out_ready = 1'b0; flush = 1'b0;

    // Reset state
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc",    out_pc,         64'd0);
    check("rst_out_inst",  64'(out_inst),  64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    // 1: aligned packet splits into two entries, visible next cycle
    in_valid = 1'b1; in_pc = RESET_PC; in_data = 64'h0041_0113_0000_0513;
    tick();
    in_valid = 1'b0;
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_out_pc",    out_pc,         64'h8000_0000);
    check("t1_out_inst",  64'(out_inst),  64'h0000_0513);
    check("t1_count",     64'(out_count), 64'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_deq_pc",   out_pc,        64'h8000_0004);
    check("t1_deq_inst", 64'(out_inst), 64'h0041_0113);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 2: pc[2]=1 writes only the upper word
    in_valid = 1'b1; in_pc = 64'h8000_0004;
    tick();
    in_valid = 1'b0;
    check("t2_count", 64'(out_count), 64'd1);
    check("t2_pc",    out_pc,         64'h8000_0004);
    check("t2_inst",  64'(out_inst),  64'h0041_0113);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2_empty", 64'(out_count), 64'd0);

    // 4: wptr is now 3, so this pair straddles the wrap (idx 3 then 0)
    in_valid = 1'b1; in_pc = 64'h8000_0010; in_data = {INST_NOP, 32'h0015_0513};
    tick();
    in_valid = 1'b0;
    check("t4_first_pc", out_pc, 64'h8000_0010);
    out_ready = 1'b1;
    tick();
    check("t4_second_pc",   out_pc,        64'h8000_0014);
    check("t4_second_inst", 64'(out_inst), 64'(INST_NOP));
    tick();
    out_ready = 1'b0;

    // 3: fill with out_ready=0; in_ready reopens only at count=2
    in_valid = 1'b1; in_pc = 64'h8000_0100; in_data = 64'h1111_1111_2222_2222;
    tick();
    in_pc = 64'h8000_0108; in_data = 64'h3333_3333_4444_4444;
    tick();
    in_pc = 64'h8000_0110; in_data = 64'h5555_5555_6666_6666;
    #1;
    check("t3_full_in_ready", 64'(in_ready),  64'd0);
    check("t3_full_count",    64'(out_count), 64'd4);
    out_ready = 1'b1;
    tick();
    check("t3_cnt3_count",    64'(out_count), 64'd3);
    check("t3_cnt3_in_ready", 64'(in_ready),  64'd0);
    tick();
    check("t3_cnt2_count",    64'(out_count), 64'd2);
    check("t3_cnt2_in_ready", 64'(in_ready),  64'd1);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("t3_refill_count", 64'(out_count), 64'd4);

    // 5: flush at count=3 with both handshakes requested
    out_ready = 1'b1;
    tick();
    check("t5_pre_count", 64'(out_count), 64'd3);
    flush = 1'b1; in_valid = 1'b1; in_pc = 64'h8000_0200; in_data = 64'h7777_7777_8888_8888;
    #1;
    check("t5_flush_in_ready",  64'(in_ready),  64'd0);
    check("t5_flush_out_valid", 64'(out_valid), 64'd0);
    tick();
    flush = 1'b0;
    check("t5_post_count", 64'(out_count), 64'd0);
    tick();
    in_valid = 1'b0;
    check("t5_reoffer_pc", out_pc, 64'h8000_0200);
    tick();
    tick();
    out_ready = 1'b0;
    check("t5_drained", 64'(out_count), 64'd0);

    // 6: asynchronous reset mid-operation
    in_valid = 1'b1; in_pc = 64'h8000_0300; in_data = 64'h9999_9999_aaaa_aaaa;
    tick();
    in_valid = 1'b0;
    check("t6_pre_count", 64'(out_count), 64'd2);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_count",     64'(out_count), 64'd0);
    check("t6_rst_in_ready",  64'(in_ready),  64'd0);
    sb.delete();
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    check("t6_rel_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_pc = 64'h8000_0404; in_data = 64'hbbbb_bbbb_cccc_cccc;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fetch_buffer
